reg_bank_scheduler: RTL and testbench

Round-robin scheduler that shares a bank of NREG 16-bit FunSel registers (decrement/increment/load/clear, enable-gated) between NREQ requesters. A granted requester issues one operation, repeated for a burst count, on one selected register. The block drives the bank's per-register enable plus a shared FunSel/data bus, and sits between the control logic and the register bank.

---
 rtl/reg_bank_scheduler.sv | 169 ++++++++++++++++
 tb/tb_reg_bank_scheduler.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_bank_scheduler.sv
// Round-robin scheduler sharing a bank of FunSel registers between requesters.
// A granted requester applies one FunSel operation, repeated for its burst count, to one register.
module reg_bank_scheduler #(
  parameter int unsigned NREQ  = 2,
  parameter int unsigned NREG  = 4,
  parameter int unsigned SEL_W = 2,
  parameter int unsigned CNT_W = 4
) (
  input  logic                    Clock,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [2*NREQ-1:0]       op_fs,
  input  logic [SEL_W*NREQ-1:0]   op_sel,
  input  logic [CNT_W*NREQ-1:0]   op_cnt,
  input  logic [16*NREQ-1:0]      op_data,
  output logic [NREQ-1:0]         gnt,
  output logic [NREQ-1:0]         done,
  output logic                    err,
  output logic                    busy,
  output logic [NREG-1:0]         reg_E,
  output logic [1:0]              reg_FunSel,
  output logic [15:0]             reg_I
);

  localparam int unsigned REQ_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [REQ_W-1:0]   last_q, last_d;
  logic [REQ_W-1:0]   w_q, w_d;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic [NREQ-1:0]    gnt_q, gnt_d;
  logic [NREQ-1:0]    done_q, done_d;
  logic               err_q, err_d;
  logic               busy_q, busy_d;
  logic [NREG-1:0]    e_q, e_d;
  logic [1:0]         fs_q, fs_d;
  logic [15:0]        i_q, i_d;

  logic [1:0]         fs_a   [NREQ];
  logic [SEL_W-1:0]   sel_a  [NREQ];
  logic [CNT_W-1:0]   cnt_a  [NREQ];
  logic [15:0]        data_a [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign fs_a[g]   = op_fs[2*g +: 2];
    assign sel_a[g]  = op_sel[SEL_W*g +: SEL_W];
    assign cnt_a[g]  = op_cnt[CNT_W*g +: CNT_W];
    assign data_a[g] = op_data[16*g +: 16];
  end

  // Round-robin search starting just after the last served requester.
  logic               found;
  logic [REQ_W-1:0]   win;
  logic [REQ_W:0]     cand;

  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = {1'b0, last_q} + (REQ_W+1)'(k);
      if (cand >= (REQ_W+1)'(NREQ)) cand = cand - (REQ_W+1)'(NREQ);
      if (!found && req[cand[REQ_W-1:0]]) begin
        found = 1'b1;
        win   = cand[REQ_W-1:0];
      end
    end
  end

  logic [1:0]       fs_w;
  logic [SEL_W-1:0] sel_w;
  logic [CNT_W-1:0] cnt_w;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    w_d     = w_q;
    rem_d   = rem_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    err_d   = 1'b0;
    busy_d  = busy_q;
    e_d     = e_q;
    fs_d    = fs_q;
    i_d     = i_q;
    fs_w    = fs_a[win];
    sel_w   = sel_a[win];
    cnt_w   = cnt_a[win];
    unique case (state_q)
      IDLE: begin
        if (found) begin
          w_d    = win;
          gnt_d  = NREQ'(1) << win;
          busy_d = 1'b1;
          if (32'(sel_w) < NREG) begin
            state_d = RUN;
            e_d     = NREG'(1) << sel_w;
            fs_d    = fs_w;
            i_d     = data_a[win];
            rem_d   = (cnt_w == '0 || fs_w[1]) ? CNT_W'(1) : cnt_w;
          end else begin
            // Out-of-range select completes immediately; bus and enables stay untouched.
            state_d = DONE;
            done_d  = NREQ'(1) << win;
            err_d   = 1'b1;
            last_d  = win;
          end
        end
      end
      RUN: begin
        if (rem_q == CNT_W'(1)) begin
          state_d = DONE;
          gnt_d   = '0;
          e_d     = '0;
          done_d  = NREQ'(1) << w_q;
          last_d  = w_q;
        end else begin
          rem_d = rem_q - CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
        e_d     = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      last_q  <= REQ_W'(NREQ - 1);
      w_q     <= '0;
      rem_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      e_q     <= '0;
      fs_q    <= '0;
      i_q     <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      w_q     <= w_d;
      rem_q   <= rem_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      e_q     <= e_d;
      fs_q    <= fs_d;
      i_q     <= i_d;
    end
  end

  assign gnt        = gnt_q;
  assign done       = done_q;
  assign err        = err_q;
  assign busy       = busy_q;
  assign reg_E      = e_q;
  assign reg_FunSel = fs_q;
  assign reg_I      = i_q;

endmodule

// File: tb/tb_reg_bank_scheduler.sv
// Bench for reg_bank_scheduler: transaction-queue model of expected outputs plus a register-bank model.
module tb_reg_bank_scheduler;
  localparam int NREQ  = 2;
  localparam int NREG  = 4;
  localparam int SEL_W = 3;
  localparam int CNT_W = 4;

  logic                  Clock = 1'b0;
  logic                  rst   = 1'b1;
  logic [NREQ-1:0]       req     = '0;
  logic [2*NREQ-1:0]     op_fs   = '0;
  logic [SEL_W*NREQ-1:0] op_sel  = '0;
  logic [CNT_W*NREQ-1:0] op_cnt  = '0;
  logic [16*NREQ-1:0]    op_data = '0;
  logic [NREQ-1:0]       gnt, done;
  logic                  err, busy;
  logic [NREG-1:0]       reg_E;
  logic [1:0]            reg_FunSel;
  logic [15:0]           reg_I;

  always #5 Clock = ~Clock;

  reg_bank_scheduler #(.NREQ(NREQ), .NREG(NREG), .SEL_W(SEL_W), .CNT_W(CNT_W)) dut (
    .Clock(Clock), .rst(rst), .req(req), .op_fs(op_fs), .op_sel(op_sel),
    .op_cnt(op_cnt), .op_data(op_data), .gnt(gnt), .done(done), .err(err),
    .busy(busy), .reg_E(reg_E), .reg_FunSel(reg_FunSel), .reg_I(reg_I)
  );

  typedef struct packed {
    logic [NREQ-1:0] gnt;
    logic [NREQ-1:0] done;
    logic            err;
    logic            busy;
    logic [NREG-1:0] e;
    logic [1:0]      fs;
    logic [15:0]     d;
  } rec_t;

  rec_t        q[$];
  rec_t        exp_r;
  logic [15:0] bank [NREG];
  int          errors = 0;
  int          checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  // Model: on accepting a request, queue the whole expected output schedule
  // (rem RUN cycles, one DONE cycle, one quiet cycle before the next sample).
  initial begin : model
    int          rr, w, rem;
    logic [1:0]  f, hfs;
    logic [SEL_W-1:0] s;
    logic [CNT_W-1:0] c;
    logic [15:0] hd;
    rec_t        t;
    exp_r = '0; rr = NREQ - 1; hfs = '0; hd = '0;
    for (int r = 0; r < NREG; r++) bank[r] = '0;
    forever begin
      @(posedge Clock or negedge rst);
      if (!rst) begin
        q.delete(); exp_r = '0; rr = NREQ - 1; hfs = '0; hd = '0;
      end else begin
        for (int r = 0; r < NREG; r++)
          if (reg_E[r])
            case (reg_FunSel)
              2'b00:   bank[r] = bank[r] - 16'd1;
              2'b01:   bank[r] = bank[r] + 16'd1;
              2'b10:   bank[r] = reg_I;
              default: bank[r] = '0;
            endcase
        if (q.size() == 0 && req != '0) begin
          w = -1;
          for (int k = 1; k <= NREQ; k++)
            if (w < 0 && req[(rr + k) % NREQ]) w = (rr + k) % NREQ;
          f = op_fs[2*w +: 2];
          s = op_sel[SEL_W*w +: SEL_W];
          c = op_cnt[CNT_W*w +: CNT_W];
          t = '0;
          t.gnt  = NREQ'(1 << w);
          t.busy = 1'b1;
          if (int'(s) >= NREG) begin
            t.done = NREQ'(1 << w); t.err = 1'b1; t.fs = hfs; t.d = hd;
            q.push_back(t);
          end else begin
            hfs = f; hd = op_data[16*w +: 16];
            rem = (c == 0 || f[1]) ? 1 : int'(c);
            t.e = NREG'(1 << s); t.fs = hfs; t.d = hd;
            repeat (rem) q.push_back(t);
            t.gnt = '0; t.e = '0; t.done = NREQ'(1 << w);
            q.push_back(t);
          end
          t = '0; t.fs = hfs; t.d = hd;
          q.push_back(t);
          rr = w;
        end
        if (q.size() != 0) exp_r = q.pop_front();
        else begin exp_r = '0; exp_r.fs = hfs; exp_r.d = hd; end
      end
    end
  end

  initial begin : compare
    rec_t act;
    forever begin
      @(negedge Clock);
      act = {gnt, done, err, busy, reg_E, reg_FunSel, reg_I};
      checks++;
      if (act !== exp_r) begin
        errors++;
        $display("FAIL outputs @%0t: got %h expected %h", $time, act, exp_r);
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic do_req(input int i, input logic [1:0] f, input logic [SEL_W-1:0] s,
                        input logic [CNT_W-1:0] c, input logic [15:0] d,
                        output int gc, output int ec, output int bc, output bit es,
                        output logic [15:0] iv, output logic [1:0] fv, output bit ok);
    gc = 0; ec = 0; bc = 0; es = 1'b0; iv = '0; fv = '0; ok = 1'b0;
    op_fs[2*i +: 2] = f;
    op_sel[SEL_W*i +: SEL_W] = s;
    op_cnt[CNT_W*i +: CNT_W] = c;
    op_data[16*i +: 16] = d;
    req[i] = 1'b1;
    for (int n = 0; n < 40 && !ok; n++) begin
      @(negedge Clock);
      if (gnt[i]) gc++;
      if (reg_E != '0) begin ec++; iv = reg_I; fv = reg_FunSel; end
      if (busy) bc++;
      if (err && gnt[i] && done[i]) es = 1'b1;
      if (done[i]) begin ok = 1'b1; req[i] = 1'b0; end
    end
  endtask

  initial begin : stim
    int gc, ec, bc, n, nd, cyc;
    bit es, ok;
    logic [15:0] iv;
    logic [1:0] fv, pg;
    int gw[$];
    int gt[$];

    #1 rst = 1'b0;
    repeat (2) @(negedge Clock);
    check("reset_outputs", 32'({gnt, done, err, busy, reg_E, reg_FunSel, reg_I}), 0);
    rst = 1'b1;

    // Increment R2 three times.
    do_req(0, 2'b01, 3'd2, 4'd3, 16'h1234, gc, ec, bc, es, iv, fv, ok);
    check("s1_done", ok, 1);
    check("s1_gnt_cycles", gc, 3);
    check("s1_regE_cycles", ec, 3);
    check("s1_busy_cycles", bc, 4);
    check("s1_funsel", fv, 2'b01);
    check("s1_R2", bank[2], 16'd3);

    // Both held: last served was 0, so grants go 1,0,1,0, three cycles apart.
    op_fs = 4'b0101; op_sel = {3'd1, 3'd0}; op_cnt = {4'd1, 4'd1};
    req = 2'b11; pg = '0; cyc = 0;
    while (gw.size() < 4 && cyc < 40) begin
      @(negedge Clock);
      cyc++;
      if (gnt != '0 && pg == '0) begin gw.push_back(gnt[1] ? 1 : 0); gt.push_back(cyc); end
      pg = gnt;
    end
    req = '0;
    check("s2_grant_count", gw.size(), 4);
    for (int k = 0; k < gw.size(); k++) check("s2_winner", gw[k], (k + 1) % 2);
    for (int k = 1; k < gt.size(); k++) check("s2_spacing", gt[k] - gt[k-1], 3);
    repeat (4) @(negedge Clock);

    // Load ignores the burst count.
    do_req(1, 2'b10, 3'd1, 4'd5, 16'hBEEF, gc, ec, bc, es, iv, fv, ok);
    check("s3_done", ok, 1);
    check("s3_run_cycles", gc, 1);
    check("s3_reg_I", iv, 16'hBEEF);
    check("s3_R1", bank[1], 16'hBEEF);

    // Out-of-range select.
    do_req(0, 2'b01, 3'd5, 4'd2, 16'h0000, gc, ec, bc, es, iv, fv, ok);
    check("s4_done", ok, 1);
    check("s4_gnt_cycles", gc, 1);
    check("s4_regE_cycles", ec, 0);
    check("s4_busy_cycles", bc, 1);
    check("s4_err_gnt_done", es, 1);

    // Clear R0, then a zero-count decrement wraps it.
    do_req(0, 2'b11, 3'd0, 4'd1, 16'h0000, gc, ec, bc, es, iv, fv, ok);
    check("s5_clear_R0", bank[0], 16'h0000);
    do_req(0, 2'b00, 3'd0, 4'd0, 16'h0000, gc, ec, bc, es, iv, fv, ok);
    check("s5_done", ok, 1);
    check("s5_run_cycles", gc, 1);
    check("s5_R0_wrap", bank[0], 16'hFFFF);

    // Reset in the middle of an 8-long burst on R3.
    op_fs[1:0] = 2'b01; op_sel[2:0] = 3'd3; op_cnt[3:0] = 4'd8;
    req[0] = 1'b1;
    n = 0;
    do begin @(negedge Clock); n++; end while (!gnt[0] && n < 10);
    check("s6_grant", gnt[0], 1);
    nd = 0;
    repeat (3) begin @(negedge Clock); if (done != '0) nd++; end
    #2 rst = 1'b0;
    #1;
    check("s6_async_reset", 32'({gnt, done, err, busy, reg_E, reg_FunSel, reg_I}), 0);
    check("s6_R3", bank[3], 16'd3);
    check("s6_no_done", nd, 0);
    req = '0;
    @(negedge Clock);
    rst = 1'b1;
    do_req(1, 2'b01, 3'd2, 4'd1, 16'h0000, gc, ec, bc, es, iv, fv, ok);
    check("s6_req1_after_reset", ok, 1);
    check("s6_R2", bank[2], 16'd4);

    // After reset requester 0 has priority when both ask.
    @(negedge Clock);
    #2 rst = 1'b0;
    @(negedge Clock);
    rst = 1'b1;
    op_cnt = {4'd1, 4'd1};
    req = 2'b11;
    n = 0;
    do begin @(negedge Clock); n++; end while (gnt == '0 && n < 10);
    check("s7_first_grant", gnt, 2'b01);
    req = '0;
    repeat (4) @(negedge Clock);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
